// File: rtl/frame_sched_if.sv
// Pixel-stream and control bundle of the frame scheduler. The master drives the
// decoded stream and the controls; the slave returns the gated stream and status.
interface frame_sched_if #(
   parameter int SKIP_W = 4,
   parameter int LVL_W  = 12
);
   logic              enable;
   logic [SKIP_W-1:0] skip;
   logic [LVL_W-1:0]  fifo_level;
   logic [LVL_W-1:0]  fifo_hi_th;
   logic              pvalid_in;
   logic              vsync_in;
   logic              pvalid_out;
   logic              vsync_out;
   logic              frame_start;
   logic              frame_drop;
   logic [15:0]       frames_sent;
   logic [15:0]       frames_dropped;
   logic [1:0]        state;

   modport master (
      output enable, skip, fifo_level, fifo_hi_th, pvalid_in, vsync_in,
      input  pvalid_out, vsync_out, frame_start, frame_drop,
             frames_sent, frames_dropped, state
   );
   modport slave (
      input  enable, skip, fifo_level, fifo_hi_th, pvalid_in, vsync_in,
      output pvalid_out, vsync_out, frame_start, frame_drop,
             frames_sent, frames_dropped, state
   );
endinterface

// File: rtl/frame_sched.sv
// Per-frame scheduler: at each vsync rising edge decides whether the coming
// frame is passed to the encoder, decimated, or dropped for FIFO congestion.
module frame_sched #(
   parameter int SKIP_W = 4,
   parameter int LVL_W  = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   frame_sched_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, SKIP = 2'd2} state_e;

   state_e            state_q, state_d;
   logic [SKIP_W-1:0] cnt_q, cnt_d;
   logic              vs_q;
   logic              vs_edge, pass_now, congested;
   logic              start_d, drop_d;
   logic              pvalid_q, vsync_q, start_q, drop_q;
   logic [15:0]       sent_q, sent_d, dropped_q, dropped_d;
   logic [LVL_W-1:0]  lvl, hi_th;

   assign lvl       = bus.fifo_level;
   assign hi_th     = bus.fifo_hi_th;
   assign vs_edge   = bus.vsync_in & ~vs_q;
   assign congested = (lvl >= hi_th);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      start_d = 1'b0;
      drop_d  = 1'b0;
      if (vs_edge) begin
         if (!bus.enable) begin
            state_d = IDLE;
         end else if (cnt_q == '0) begin
            if (!congested) begin
               state_d = PASS;
               cnt_d   = bus.skip;
               start_d = 1'b1;
            end else begin
               state_d = SKIP;
               drop_d  = 1'b1;
            end
         end else begin
            state_d = SKIP;
            cnt_d   = cnt_q - 1'b1;
         end
      end
      // IDLE always re-arms decimation so the first enabled frame is a candidate
      if (state_d == IDLE) cnt_d = '0;
   end

   // The edge cycle already uses the new decision, so vsync_out is never clipped
   assign pass_now  = vs_edge ? (state_d == PASS) : (state_q == PASS);

   assign sent_d    = (start_d && sent_q != 16'hFFFF)    ? sent_q + 16'd1    : sent_q;
   assign dropped_d = (drop_d  && dropped_q != 16'hFFFF) ? dropped_q + 16'd1 : dropped_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         vs_q      <= 1'b0;
         pvalid_q  <= 1'b0;
         vsync_q   <= 1'b0;
         start_q   <= 1'b0;
         drop_q    <= 1'b0;
         sent_q    <= '0;
         dropped_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         vs_q      <= bus.vsync_in;
         pvalid_q  <= bus.pvalid_in & pass_now;
         vsync_q   <= bus.vsync_in & pass_now;
         start_q   <= start_d;
         drop_q    <= drop_d;
         sent_q    <= sent_d;
         dropped_q <= dropped_d;
      end
   end

   assign bus.pvalid_out     = pvalid_q;
   assign bus.vsync_out      = vsync_q;
   assign bus.frame_start    = start_q;
   assign bus.frame_drop     = drop_q;
   assign bus.frames_sent    = sent_q;
   assign bus.frames_dropped = dropped_q;
   assign bus.state          = state_q;
endmodule
